icache_control_master: RTL

- Initiator side of the icache control-word store (256 sets × 7 bits: {3 pLRU, 4 valid}).
- Sequences lookup, fill and code-invalidate requests from the icache into read_do, write_do and invdcode_do handshakes.
- Computes hit/victim way and updated pLRU/valid bits.
- Sits between the icache tag compare logic and the control RAM.

---
 rtl/icache_control_master_pkg.sv | 39 +++
 rtl/icache_plru_calc.sv | 41 ++++
 rtl/icache_control_master.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/icache_control_master_pkg.sv
// Shared definitions for the icache control-word master: word field positions,
// FSM encodings, set-index slice and the pLRU touch rule.
package icache_control_master_pkg;

  localparam int PLRU_MSB  = 6;
  localparam int PLRU_LSB  = 4;
  localparam int VALID_MSB = 3;

  localparam int SET_MSB = 11;
  localparam int SET_LSB = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_INVD    = 2'd3;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_FILL   = 1'b1
  } op_e;

  // plru = {b2, b1, b0}; touching a way points the tree away from it
  function automatic logic [2:0] plru_touch(input logic [2:0] plru, input logic [1:0] way);
    logic [2:0] p;
    p = plru;
    case (way)
      2'd0: begin p[0] = 1'b1; p[1] = 1'b1; end
      2'd1: begin p[0] = 1'b1; p[1] = 1'b0; end
      2'd2: begin p[0] = 1'b0; p[2] = 1'b1; end
      default: begin p[0] = 1'b0; p[2] = 1'b0; end
    endcase
    return p;
  endfunction

  function automatic logic [7:0] set_index(input logic [31:0] addr);
    return addr[SET_MSB:SET_LSB];
  endfunction

endpackage

// File: rtl/icache_plru_calc.sv
// Combinational hit/victim resolution and pLRU update for one 4-way control word.
module icache_plru_calc
  import icache_control_master_pkg::*;
(
  input  logic [6:0] word,
  input  logic [3:0] hit_mask,
  output logic       hit,
  output logic [1:0] way,
  output logic [1:0] victim,
  output logic [6:0] upd_word
);

  logic [3:0] valid;
  logic [2:0] plru;
  logic [3:0] eff;

  assign valid = word[VALID_MSB:0];
  assign plru  = word[PLRU_MSB:PLRU_LSB];
  assign eff   = hit_mask & valid;

  always_comb begin
    hit = |eff;

    // multi-hot tag matches resolve to the lowest way
    if (eff[0])      way = 2'd0;
    else if (eff[1]) way = 2'd1;
    else if (eff[2]) way = 2'd2;
    else if (eff[3]) way = 2'd3;
    else             way = 2'd0;

    if (!valid[0])      victim = 2'd0;
    else if (!valid[1]) victim = 2'd1;
    else if (!valid[2]) victim = 2'd2;
    else if (!valid[3]) victim = 2'd3;
    else if (plru[0])   victim = plru[2] ? 2'd3 : 2'd2;
    else                victim = plru[1] ? 2'd1 : 2'd0;

    upd_word = {plru_touch(plru, way), valid};
  end

endmodule

// File: rtl/icache_control_master.sv
// Initiator for the icache control-word RAM: turns lookup, fill and invalidate
// requests into read/write/invdcode handshakes and resolves hit or victim way.
module icache_control_master
  import icache_control_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        lookup_do,
  input  logic [31:0] lookup_address,
  input  logic [3:0]  hit_vector,
  output logic        lookup_done,
  output logic        lookup_hit,
  output logic [1:0]  lookup_way,

  input  logic        fill_do,
  input  logic [31:0] fill_address,
  input  logic [1:0]  fill_way,
  output logic        fill_done,

  input  logic        invd_do,
  output logic        invd_done,

  output logic        busy,

  output logic [31:0] ctrl_address,
  output logic        ctrl_read_do,
  input  logic [6:0]  ctrl_q,
  output logic        ctrl_write_do,
  output logic [6:0]  ctrl_data,
  output logic        ctrl_invdcode_do,
  input  logic        ctrl_invdcode_done
);

  logic [1:0]  state;

  logic [31:0] addr_p0;
  op_e         op_p0;
  logic [1:0]  fill_way_p0;

  logic [6:0]  word_p1;
  logic        hit_p1;
  logic [1:0]  way_p1;
  logic        vld_p1;

  logic        calc_hit;
  logic [1:0]  calc_way;
  logic [1:0]  calc_victim;
  logic [6:0]  calc_word;
  logic [6:0]  fill_word;

  logic        idle;
  logic        take_invd;
  logic        take_fill;
  logic        take_lookup;

  icache_plru_calc u_plru_calc (
    .word     (ctrl_q),
    .hit_mask (hit_vector),
    .hit      (calc_hit),
    .way      (calc_way),
    .victim   (calc_victim),
    .upd_word (calc_word)
  );

  assign idle        = (state == ST_IDLE);
  assign take_invd   = idle && invd_do;
  assign take_fill   = idle && !invd_do && fill_do;
  assign take_lookup = idle && !invd_do && !fill_do && lookup_do;

  assign fill_word = {plru_touch(ctrl_q[PLRU_MSB:PLRU_LSB], fill_way_p0),
                      ctrl_q[VALID_MSB:0] | (4'b0001 << fill_way_p0)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_p0     <= '0;
      op_p0       <= OP_LOOKUP;
      fill_way_p0 <= '0;
      word_p1     <= '0;
      hit_p1      <= 1'b0;
      way_p1      <= '0;
      vld_p1      <= 1'b0;
    end else begin
      case (state)
        // p0: request accepted, RAM read issued
        ST_IDLE: begin
          if (take_invd) begin
            state <= ST_INVD;
          end else if (take_fill) begin
            state       <= ST_COMPARE;
            op_p0       <= OP_FILL;
            addr_p0     <= fill_address;
            fill_way_p0 <= fill_way;
          end else if (take_lookup) begin
            state   <= ST_COMPARE;
            op_p0   <= OP_LOOKUP;
            addr_p0 <= lookup_address;
          end
        end
        // p1: control word returned, resolve and register the write-back
        ST_COMPARE: begin
          state <= ST_WRITE;
          if (op_p0 == OP_FILL) begin
            word_p1 <= fill_word;
            vld_p1  <= 1'b1;
          end else begin
            word_p1 <= calc_word;
            vld_p1  <= calc_hit;
            hit_p1  <= calc_hit;
            way_p1  <= calc_hit ? calc_way : calc_victim;
          end
        end
        ST_WRITE: begin
          state  <= ST_IDLE;
          vld_p1 <= 1'b0;
        end
        default: begin
          if (ctrl_invdcode_done) state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    if (take_fill)                                        ctrl_address = fill_address;
    else if (take_lookup)                                 ctrl_address = lookup_address;
    else if (state == ST_COMPARE || state == ST_WRITE)    ctrl_address = addr_p0;
    else                                                  ctrl_address = '0;
  end

  assign busy             = !idle;
  assign ctrl_read_do     = take_fill || take_lookup;
  assign ctrl_write_do    = (state == ST_WRITE) && vld_p1;
  assign ctrl_data        = ctrl_write_do ? word_p1 : 7'd0;
  // held high through RAM init; the RAM ignores it until it is ready
  assign ctrl_invdcode_do = (state == ST_INVD) && !ctrl_invdcode_done;
  assign invd_done        = (state == ST_INVD) && ctrl_invdcode_done;
  assign lookup_done      = (state == ST_WRITE) && (op_p0 == OP_LOOKUP);
  assign fill_done        = (state == ST_WRITE) && (op_p0 == OP_FILL);
  assign lookup_hit       = hit_p1;
  assign lookup_way       = way_p1;

endmodule
